spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 47 ++++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: register map, CTRL/STATUS bit positions, FSM encoding and
// frame bit helpers used by both SPI slave and master.
package spi_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned STAT_W = 5;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_CPOL     = 1;
  localparam int unsigned CTRL_CPHA     = 2;
  localparam int unsigned CTRL_LEN16    = 3;
  localparam int unsigned CTRL_LSBFIRST = 4;
  localparam int unsigned CTRL_IE       = 5;

  localparam int unsigned STAT_RXVALID = 0;
  localparam int unsigned STAT_TXFULL  = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVR     = 3;
  localparam int unsigned STAT_ABORT   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } spi_state_e;

  // Bit that goes on the wire next, given frame length and bit order.
  function automatic logic frame_bit(input logic [DATA_W-1:0] v, input logic len16,
                                     input logic lsb);
    if (lsb) return v[0];
    return len16 ? v[15] : v[7];
  endfunction

  function automatic logic [DATA_W-1:0] frame_shift(input logic [DATA_W-1:0] v,
                                                    input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, d});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Memory-mapped SPI slave: 4-register CPU block, oversampled SCK/SS, modes 0-3,
// 8/16-bit frames, either bit order, overrun/abort flags and level interrupt.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h30,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        SCK,
  input  logic        MOSI,
  input  logic        SS,
  output logic        MISO,
  output logic        MISO_OE,
  output logic        interrpt
);

  logic [CTRL_W-1:0]      ctrl;
  logic [DATA_W-1:0]      tx_hold, rx_data, tx_sh, rx_sh;
  logic                   rx_valid, tx_full, busy, ovr, abort;
  logic [CNT_W-1:0]       bit_cnt;
  spi_state_e             state;
  logic [SYNC_STAGES-1:0] mosi_q;

  logic sck_lvl, sck_rise_c, sck_fall_c, ss_lvl, ss_rise_c, ss_fall_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk_cpu), .rst(rst), .d(SCK), .level(sck_lvl), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk_cpu), .rst(rst), .d(SS), .level(ss_lvl), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );

  // MOSI gets the same depth as SCK so data lines up with the detected edge.
  always_ff @(posedge clk_cpu) begin
    if (!rst) mosi_q <= '0;
    else      mosi_q <= SYNC_STAGES'({mosi_q, MOSI});
  end

  logic [31:0]       offset_c, rdata_c;
  logic [1:0]        reg_sel_c;
  logic [STAT_W-1:0] status_c;
  logic              hit_c, wr_c, rd_c, tx_wr_c, rd_rx_c;
  logic              lead_c, trail_c, sample_c, shift_c, abort_c, len16, lsb, drive_c;
  logic [DATA_W-1:0] load_val_c, rx_next_c;
  logic              unused_bits;

  assign offset_c  = cpu_addr - ADDR_BASE;
  assign reg_sel_c = offset_c[1:0];
  assign hit_c     = cpu_valid & ~cpu_instr & (offset_c < 32'd4) & ~mem_ready;
  assign wr_c      = hit_c & (|cpu_wstrb);
  assign rd_c      = hit_c & ~(|cpu_wstrb);
  assign tx_wr_c   = wr_c & (reg_sel_c == REG_TXDATA);
  assign rd_rx_c   = rd_c & (reg_sel_c == REG_RXDATA);

  assign len16    = ctrl[CTRL_LEN16];
  assign lsb      = ctrl[CTRL_LSBFIRST];
  assign lead_c   = ctrl[CTRL_CPOL] ? sck_fall_c : sck_rise_c;
  assign trail_c  = ctrl[CTRL_CPOL] ? sck_rise_c : sck_fall_c;
  assign sample_c = ctrl[CTRL_CPHA] ? trail_c : lead_c;
  assign shift_c  = ctrl[CTRL_CPHA] ? lead_c : trail_c;
  assign abort_c  = ss_rise_c | ~ctrl[CTRL_EN];
  assign drive_c  = ctrl[CTRL_EN] & ~ss_lvl;

  assign load_val_c = tx_full ? tx_hold : '0;
  // 8-bit LSB-first frames fill from bit 7 so the result lands in [7:0].
  assign rx_next_c  = lsb ? (len16 ? {mosi_q[SYNC_STAGES-1], rx_sh[15:1]}
                                   : {8'h00, mosi_q[SYNC_STAGES-1], rx_sh[7:1]})
                          : {rx_sh[14:0], mosi_q[SYNC_STAGES-1]};

  assign unused_bits = ^{cpu_wdata[31:16], sck_lvl};

  always_comb begin
    status_c               = '0;
    status_c[STAT_RXVALID] = rx_valid;
    status_c[STAT_TXFULL]  = tx_full;
    status_c[STAT_BUSY]    = busy;
    status_c[STAT_OVR]     = ovr;
    status_c[STAT_ABORT]   = abort;
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      REG_TXDATA: rdata_c = 32'(tx_hold);
      REG_RXDATA: rdata_c = 32'(rx_data);
      REG_STATUS: rdata_c = 32'(status_c);
      REG_CTRL:   rdata_c = 32'(ctrl);
      default:    rdata_c = '0;
    endcase
  end

  // CPU side effects first; frame engine after so its updates take priority.
  always_ff @(posedge clk_cpu) begin
    if (!rst) begin
      ctrl      <= '0;
      tx_hold   <= '0;
      rx_data   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_valid  <= 1'b0;
      tx_full   <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
      abort     <= 1'b0;
      bit_cnt   <= '0;
      state     <= S_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      MISO      <= 1'b0;
      MISO_OE   <= 1'b0;
      interrpt  <= 1'b0;
    end else begin
      mem_ready <= hit_c;
      mem_rdata <= rd_c ? rdata_c : '0;
      MISO_OE   <= drive_c;
      interrpt  <= ctrl[CTRL_IE] & (rx_valid | abort);

      if (wr_c) begin
        case (reg_sel_c)
          REG_TXDATA: begin
            tx_hold <= cpu_wdata[DATA_W-1:0];
            tx_full <= 1'b1;
          end
          REG_STATUS: begin
            if (cpu_wdata[STAT_OVR])   ovr   <= 1'b0;
            if (cpu_wdata[STAT_ABORT]) abort <= 1'b0;
          end
          REG_CTRL: ctrl <= cpu_wdata[CTRL_W-1:0];
          default: ;
        endcase
      end
      if (rd_rx_c) begin
        rx_valid <= 1'b0;
        ovr      <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (ctrl[CTRL_EN] && ss_fall_c) state <= S_LOAD;
        end
        S_LOAD: begin
          if (abort_c) begin
            abort <= 1'b1;
            state <= S_IDLE;
          end else begin
            // CPHA=0 puts the first bit out now; CPHA=1 waits for the leading edge.
            if (ctrl[CTRL_CPHA]) begin
              tx_sh <= load_val_c;
              MISO  <= 1'b0;
            end else begin
              tx_sh <= frame_shift(load_val_c, lsb);
              MISO  <= frame_bit(load_val_c, len16, lsb);
            end
            if (!tx_wr_c) tx_full <= 1'b0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort_c) begin
            abort <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (sample_c) begin
            rx_sh   <= rx_next_c;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == (len16 ? CNT_W'(15) : CNT_W'(7))) state <= S_DONE;
          end else if (shift_c) begin
            MISO  <= frame_bit(tx_sh, len16, lsb);
            tx_sh <= frame_shift(tx_sh, lsb);
          end
        end
        S_DONE: begin
          rx_data  <= len16 ? rx_sh : {8'h00, rx_sh[7:0]};
          rx_valid <= 1'b1;
          if (rd_rx_c)       ovr <= ovr;
          else if (rx_valid) ovr <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (!drive_c) MISO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bench acts as SPI master and CPU, checks bus and wire behaviour.
module tb_spi_slave;

  localparam logic [31:0] BASE = 32'h30;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_valid, cpu_instr, mem_ready;
  logic        sck, mosi, ss, miso, miso_oe, irq;

  int n_checks = 0;
  int n_fail   = 0;

  spi_slave #(.ADDR_BASE(BASE), .SYNC_STAGES(2)) dut (
    .clk_cpu(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_valid(cpu_valid), .cpu_instr(cpu_instr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .SCK(sck), .MOSI(mosi), .SS(ss),
    .MISO(miso), .MISO_OE(miso_oe), .interrpt(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctrl;
    logic        wr_tx;
    logic [15:0] tx;
    logic [15:0] mo;
    int          extra;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_xfer(input logic [1:0] off, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
    @(negedge clk);
    cpu_addr  = BASE + 32'(off);
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
    cpu_instr = 1'b0;
    cpu_valid = 1'b1;
    @(negedge clk);
    check("mem_ready", 32'(mem_ready), 32'd1);
    rdata     = mem_rdata;
    cpu_valid = 1'b0;
    cpu_wstrb = 4'h0;
  endtask

  task automatic cpu_wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    cpu_xfer(off, d, 4'hF, dummy);
  endtask

  task automatic cpu_rd_chk(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] r;
    cpu_xfer(off, 32'h0, 4'h0, r);
    check(name, r, exp);
  endtask

  // Bench-side SPI master; extra clocks are sent after the frame with SS still low.
  task automatic spi_xfer(input logic cpol, input logic cpha, input logic lsb, input int nbits,
                          input int extra, input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    @(negedge clk);
    sck  = cpol;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits + extra; i++) begin
      int   idx;
      logic b;
      idx = lsb ? i : nbits - 1 - i;
      b   = (i < nbits) ? mo[idx[3:0]] : ~mosi;
      if (!cpha) mosi = b;
      repeat (HALF) @(negedge clk);
      sck = ~cpol;
      if (cpha) mosi = b;
      else if (i < nbits) mi[idx[3:0]] = miso;
      repeat (HALF) @(negedge clk);
      sck = cpol;
      if (cpha && i < nbits) mi[idx[3:0]] = miso;
    end
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [15:0] got;
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; cpu_valid = 1'b0;
    cpu_instr = 1'b0; sck = 1'b0; mosi = 1'b0; ss = 1'b1;

    vecs[0] = '{6'h21, 1'b1, 16'h00A5, 16'h003C, 3, 16'h00A5, 16'h003C, 1'b1};
    vecs[1] = '{6'h1F, 1'b1, 16'h8003, 16'h1234, 0, 16'h8003, 16'h1234, 1'b0};
    vecs[2] = '{6'h05, 1'b1, 16'h775A, 16'h00C3, 0, 16'h005A, 16'h00C3, 1'b0};
    vecs[3] = '{6'h0B, 1'b1, 16'hBEEF, 16'h0F0F, 0, 16'hBEEF, 16'h0F0F, 1'b0};
    vecs[4] = '{6'h11, 1'b1, 16'h0001, 16'h0080, 0, 16'h0001, 16'h0080, 1'b0};
    vecs[5] = '{6'h21, 1'b0, 16'h0000, 16'h00FF, 0, 16'h0000, 16'h00FF, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    cpu_rd_chk("rst_ctrl", 2'd3, 32'h0);
    cpu_rd_chk("rst_status", 2'd2, 32'h0);
    cpu_rd_chk("rst_rxdata", 2'd1, 32'h0);

    // Misses and instruction fetches never get a response.
    @(negedge clk);
    cpu_addr = 32'h40; cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      check("miss_addr_ready", 32'(mem_ready), 32'd0);
    end
    cpu_addr = BASE; cpu_instr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("instr_ready", 32'(mem_ready), 32'd0);
    end
    cpu_valid = 1'b0; cpu_instr = 1'b0;

    // Ready is one cycle wide even with valid held.
    cpu_wr(2'd3, 32'h0000_002A);
    @(negedge clk);
    cpu_addr = BASE + 32'd3; cpu_valid = 1'b1;
    @(negedge clk);
    check("held_ready_hi", 32'(mem_ready), 32'd1);
    check("held_rdata", mem_rdata, 32'h2A);
    @(negedge clk);
    check("held_ready_lo", 32'(mem_ready), 32'd0);
    check("held_rdata_zero", mem_rdata, 32'd0);
    cpu_valid = 1'b0;

    cpu_wr(2'd0, 32'h1111);
    cpu_rd_chk("txfull_set", 2'd2, 32'h02);
    cpu_wr(2'd0, 32'hFFFF_2222);
    cpu_rd_chk("tx_overwrite", 2'd0, 32'h2222);
    cpu_rd_chk("txfull_still", 2'd2, 32'h02);

    for (int i = 0; i < 6; i++) begin
      int nb;
      nb = vecs[i].ctrl[3] ? 16 : 8;
      cpu_wr(2'd3, 32'(vecs[i].ctrl));
      if (vecs[i].wr_tx) cpu_wr(2'd0, 32'(vecs[i].tx));
      cpu_rd_chk($sformatf("v%0d_status_pre", i), 2'd2, vecs[i].wr_tx ? 32'h02 : 32'h00);
      spi_xfer(vecs[i].ctrl[1], vecs[i].ctrl[2], vecs[i].ctrl[4], nb, vecs[i].extra,
               vecs[i].mo, got);
      check($sformatf("v%0d_miso", i), 32'(got), 32'(vecs[i].exp_miso));
      check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      cpu_rd_chk($sformatf("v%0d_status_post", i), 2'd2, 32'h01);
      cpu_rd_chk($sformatf("v%0d_rxdata", i), 2'd1, 32'(vecs[i].exp_rx));
      cpu_rd_chk($sformatf("v%0d_status_clr", i), 2'd2, 32'h00);
    end

    // Overrun: two frames without reading RXDATA.
    cpu_wr(2'd3, 32'h01);
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 0, 16'h0011, got);
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 0, 16'h0022, got);
    cpu_rd_chk("ovr_status", 2'd2, 32'h09);
    cpu_rd_chk("ovr_rxdata", 2'd1, 32'h22);
    cpu_rd_chk("ovr_cleared", 2'd2, 32'h00);

    // Abort after 5 bits keeps the previous RXDATA.
    cpu_wr(2'd3, 32'h21);
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 0, 16'h0055, got);
    spi_xfer(1'b0, 1'b0, 1'b0, 5, 0, 16'h0015, got);
    cpu_rd_chk("abort_status", 2'd2, 32'h11);
    check("abort_irq", 32'(irq), 32'd1);
    cpu_wr(2'd2, 32'h10);
    cpu_rd_chk("abort_w1c", 2'd2, 32'h01);
    cpu_rd_chk("abort_rxdata", 2'd1, 32'h55);

    // Reset in the middle of a frame.
    spi_xfer(1'b0, 1'b0, 1'b0, 8, 0, 16'h0099, got);
    check("pre_rst_irq", 32'(irq), 32'd1);
    cpu_wr(2'd0, 32'h00FF);
    @(negedge clk);
    sck = 1'b0;
    repeat (6) @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_miso", 32'(miso), 32'd1);
    check("mid_miso_oe", 32'(miso_oe), 32'd1);
    cpu_rd_chk("mid_busy", 2'd2, 32'h05);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_miso", 32'(miso), 32'd0);
    check("mrst_miso_oe", 32'(miso_oe), 32'd0);
    check("mrst_irq", 32'(irq), 32'd0);
    check("mrst_ready", 32'(mem_ready), 32'd0);
    check("mrst_rdata", mem_rdata, 32'd0);
    rst = 1'b1;
    ss  = 1'b1;
    repeat (8) @(negedge clk);
    cpu_rd_chk("mrst_ctrl", 2'd3, 32'h0);
    cpu_rd_chk("mrst_status", 2'd2, 32'h0);
    cpu_rd_chk("mrst_rxdata", 2'd1, 32'h0);
    cpu_rd_chk("mrst_txdata", 2'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
